// File: rtl/ddr_line_arbiter.sv
// ddr_line_arbiter: round-robin arbiter of icache/dcache 256-bit line requests onto one DDR controller port
// Ports: clk/rst (sync active-high); ic_req/ic_addr -> ic_rdy/ic_rdata; dc_req/dc_write/dc_addr/dc_wdata -> dc_rdy/dc_rdata;
// ram_en/ram_write/ram_addr/data_to_ram -> controller, ram_rdy/ram_rdata <- controller; grant_dc, busy, timeout_err status.
module ddr_line_arbiter #(
  parameter int TIMEOUT = 4096,
  parameter int ADDR_W  = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_rdy,
  output logic [255:0]      ic_rdata,
  input  logic              dc_req,
  input  logic              dc_write,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [255:0]      dc_wdata,
  output logic              dc_rdy,
  output logic [255:0]      dc_rdata,
  output logic              ram_en,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [255:0]      data_to_ram,
  input  logic              ram_rdy,
  input  logic [255:0]      ram_rdata,
  output logic              grant_dc,
  output logic              busy,
  output logic              timeout_err
);
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
  localparam logic [15:0] WD_SET = 16'(TIMEOUT - 2);
  state_t state;
  logic last_dc;
  logic [15:0] wd_cnt;
  logic pick_dc;
  logic [ADDR_W-1:0] sel_addr;
  // dcache wins unless icache also asks and dcache had the last turn
  assign pick_dc  = dc_req & (~ic_req | ~last_dc);
  assign sel_addr = pick_dc ? dc_addr : ic_addr;
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_dc     <= 1'b0;
      wd_cnt      <= '0;
      ic_rdy      <= 1'b0;
      dc_rdy      <= 1'b0;
      ic_rdata    <= '0;
      dc_rdata    <= '0;
      ram_en      <= 1'b0;
      ram_write   <= 1'b0;
      ram_addr    <= '0;
      data_to_ram <= '0;
      grant_dc    <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      ic_rdy <= 1'b0;
      dc_rdy <= 1'b0;
      case (state)
        IDLE: if (ic_req | dc_req) begin
          state     <= ISSUE;
          ram_en    <= 1'b1;
          busy      <= 1'b1;
          grant_dc  <= pick_dc;
          ram_write <= pick_dc & dc_write;
          ram_addr  <= sel_addr & ~ADDR_W'(7);
          wd_cnt    <= '0;
          if (pick_dc & dc_write) data_to_ram <= dc_wdata;
        end
        ISSUE: begin
          wd_cnt <= wd_cnt + {15'd0, ~&wd_cnt};
          // flag on the edge where the counter steps to TIMEOUT-1 and the transaction is still pending
          if (!ram_rdy && wd_cnt >= WD_SET) timeout_err <= 1'b1;
          if (ram_rdy) begin
            state   <= DONE;
            ram_en  <= 1'b0;
            last_dc <= grant_dc;
            ic_rdy  <= ~grant_dc;
            dc_rdy  <= grant_dc;
            if (!ram_write && grant_dc) dc_rdata <= ram_rdata;
            if (!ram_write && !grant_dc) ic_rdata <= ram_rdata;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ddr_line_arbiter.sv
// tb_ddr_line_arbiter: directed self-checking bench with a completion scoreboard
module tb_ddr_line_arbiter;
  localparam int AW = 30;
  logic clk = 0, rst = 1;
  logic ic_req = 0, dc_req = 0, dc_write = 0, ram_rdy = 0;
  logic [AW-1:0] ic_addr = '0, dc_addr = '0, ram_addr;
  logic [255:0] dc_wdata = '0, ram_rdata = '0, ic_rdata, dc_rdata, data_to_ram;
  logic ic_rdy, dc_rdy, ram_en, ram_write, grant_dc, busy, timeout_err;
  typedef struct {bit dc; logic [255:0] data;} exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0;
  localparam logic [255:0] A5 = {32{8'hA5}};
  localparam logic [255:0] C3 = {32{8'hC3}};
  localparam logic [255:0] D1 = {32{8'hD1}};
  localparam logic [255:0] I1 = {32{8'h1E}};
  localparam logic [255:0] E7 = {32{8'hE7}};
  localparam logic [255:0] P5 = {32{8'h5A}};

  always #5 clk = ~clk;

  ddr_line_arbiter #(.TIMEOUT(8), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdy(ic_rdy), .ic_rdata(ic_rdata),
    .dc_req(dc_req), .dc_write(dc_write), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_rdy(dc_rdy), .dc_rdata(dc_rdata),
    .ram_en(ram_en), .ram_write(ram_write), .ram_addr(ram_addr), .data_to_ram(data_to_ram),
    .ram_rdy(ram_rdy), .ram_rdata(ram_rdata),
    .grant_dc(grant_dc), .busy(busy), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // controller model: wait for ram_en, hold for lat cycles, then pulse ram_rdy; returns in DONE
  task automatic complete(input bit exp_dc, input logic [AW-1:0] exp_addr, input logic [255:0] rd, input int lat);
    int n = 0;
    while (ram_en !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("ram_en_rise", 256'(ram_en), 256'(1));
    chk("grant_dc", 256'(grant_dc), 256'(exp_dc));
    chk("ram_addr", 256'(ram_addr), 256'(exp_addr));
    repeat (lat) begin
      step();
      chk("ram_en_hold", 256'(ram_en), 256'(1));
    end
    ram_rdy = 1;
    ram_rdata = rd;
    step();
    ram_rdy = 0;
    ram_rdata = '0;
    chk("ram_en_fall", 256'(ram_en), 256'(0));
  endtask

  always @(negedge clk) begin
    if (!rst && (ic_rdy || dc_rdy)) begin
      checks++;
      assert (q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_rdy: observed ic_rdy=%0b dc_rdy=%0b expected no pulse", ic_rdy, dc_rdy);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rdy_owner", 256'({dc_rdy, ic_rdy}), 256'({e.dc, ~e.dc}));
        chk("rdata", e.dc ? dc_rdata : ic_rdata, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: observed no finish expected finish before 100000");
    $fatal(1, "bench timeout");
  end

  initial begin
    repeat (2) step();
    chk("rst_ram_en", 256'(ram_en), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_rdy", 256'({ic_rdy, dc_rdy}), 256'(0));
    chk("rst_grant", 256'(grant_dc), 256'(0));
    chk("rst_timeout", 256'(timeout_err), 256'(0));
    chk("rst_ram_addr", 256'(ram_addr), 256'(0));
    chk("rst_data_to_ram", data_to_ram, 256'(0));
    chk("rst_ic_rdata", ic_rdata, 256'(0));
    chk("rst_dc_rdata", dc_rdata, 256'(0));
    rst = 0;
    ic_addr = 30'h123;
    ic_req = 1;
    q.push_back('{0, A5});
    step();
    chk("ic_ram_write", 256'(ram_write), 256'(0));
    chk("ic_busy", 256'(busy), 256'(1));
    complete(0, 30'h120, A5, 3);
    chk("ic_rdy", 256'({ic_rdy, dc_rdy}), 256'(2));
    chk("ic_rdata", ic_rdata, A5);
    ic_req = 0;
    step();
    chk("ic_idle_busy", 256'(busy), 256'(0));
    chk("ic_rdy_once", 256'(ic_rdy), 256'(0));
    chk("ic_rdata_hold", ic_rdata, A5);
    dc_addr = 30'h40;
    dc_req = 1;
    q.push_back('{1, C3});
    step();
    complete(1, 30'h40, C3, 1);
    dc_req = 0;
    step();
    dc_req = 1;
    dc_write = 1;
    dc_wdata = 256'h1;
    q.push_back('{1, C3});
    step();
    chk("wr_ram_write", 256'(ram_write), 256'(1));
    chk("wr_data_to_ram", data_to_ram, 256'h1);
    complete(1, 30'h40, {32{8'hFF}}, 2);
    chk("wr_dc_rdy", 256'(dc_rdy), 256'(1));
    chk("wr_dc_rdata_kept", dc_rdata, C3);
    dc_req = 0;
    dc_write = 0;
    step();
    rst = 1;
    step();
    rst = 0;
    ic_addr = 30'h200;
    dc_addr = 30'h308;
    ic_req = 1;
    dc_req = 1;
    q.push_back('{1, D1});
    q.push_back('{0, I1});
    step();
    complete(1, 30'h308, D1, 1);
    dc_req = 0;
    step();
    chk("gap_ram_en", 256'(ram_en), 256'(0));
    step();
    complete(0, 30'h200, I1, 1);
    ic_req = 0;
    step();
    ic_req = 1;
    dc_req = 1;
    for (int k = 0; k < 4; k++) q.push_back('{k % 2 == 0, {32{8'(k + 1)}}});
    for (int k = 0; k < 4; k++) complete(k % 2 == 0, (k % 2 == 0) ? 30'h308 : 30'h200, {32{8'(k + 1)}}, 0);
    ic_req = 0;
    dc_req = 0;
    step();
    rst = 1;
    step();
    rst = 0;
    ic_addr = 30'h10;
    ic_req = 1;
    q.push_back('{0, E7});
    step();
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("timeout_cycle%0d", i), 256'(timeout_err), 256'(i == 8));
      if (i < 8) step();
    end
    repeat (3) step();
    chk("timeout_sticky", 256'(timeout_err), 256'(1));
    complete(0, 30'h10, E7, 0);
    chk("timeout_done_rdy", 256'(ic_rdy), 256'(1));
    ic_req = 0;
    step();
    chk("timeout_after", 256'(timeout_err), 256'(1));
    rst = 1;
    step();
    rst = 0;
    chk("timeout_cleared", 256'(timeout_err), 256'(0));
    ic_addr = 30'h55;
    ic_req = 1;
    step();
    step();
    rst = 1;
    step();
    chk("abort_ram_en", 256'(ram_en), 256'(0));
    chk("abort_busy", 256'(busy), 256'(0));
    chk("abort_rdy", 256'({ic_rdy, dc_rdy}), 256'(0));
    chk("abort_timeout", 256'(timeout_err), 256'(0));
    rst = 0;
    q.push_back('{0, P5});
    complete(0, 30'h50, P5, 1);
    chk("abort_new_rdy", 256'(ic_rdy), 256'(1));
    ic_req = 0;
    step();
    step();
    chk("queue_empty", 256'(q.size()), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ddr_line_arbiter.md
Name: ddr_line_arbiter

Overview:
- Upstream stage of the DDR controller.
- Arbitrates 256-bit cache-line requests from the instruction cache (read-only) and the data cache (read/write) onto the controller's single line port.
- Holds the winning request stable until the controller's completion pulse, then returns read data to the winner and pulses its ready.
- Includes a watchdog that flags a controller that never completes.

Parameters:
TIMEOUT, 4096, cycles in ISSUE before timeout_err is set (≥2)
ADDR_W, 30, width of the 4-byte-aligned word address

Ports:
clk  input  1  ui clock shared with DDR controller; all logic on rising edge
rst  input  1  synchronous, active-high reset
ic_req  input  1  icache line read request; held until ic_rdy
ic_addr  input  ADDR_W  icache word address
ic_rdy  output  1  one-cycle completion pulse to icache
ic_rdata  output  256  line returned to icache; valid while ic_rdy=1, held afterwards
dc_req  input  1  dcache request; held until dc_rdy
dc_write  input  1  1=line write, 0=line read
dc_addr  input  ADDR_W  dcache word address
dc_wdata  input  256  write line
dc_rdy  output  1  one-cycle completion pulse to dcache
dc_rdata  output  256  line returned to dcache; valid while dc_rdy=1, held afterwards
ram_en  output  1  request to DDR controller; level, held until ram_rdy
ram_write  output  1  command to controller
ram_addr  output  ADDR_W  line address to controller, low 3 bits forced 0
data_to_ram  output  256  write line to controller
ram_rdy  input  1  controller completion pulse
ram_rdata  input  256  controller read line, valid with ram_rdy
grant_dc  output  1  1 while dcache owns the current/last transaction
busy  output  1  1 in ISSUE or DONE
timeout_err  output  1  sticky watchdog flag

Behaviour:
Reset:
- State IDLE.
- All outputs 0, including ic_rdata, dc_rdata, ram_addr and data_to_ram.
- last_grant=IC, so dcache wins the first tie.
- Watchdog counter 0.

State machine: IDLE, ISSUE, DONE.
- IDLE:
  - Only dc_req: latch dcache.
  - Only ic_req: latch icache.
  - Both: grant the port not in last_grant (round-robin).
  - Latch into registers: ram_addr={addr[ADDR_W-1:3],3'b0}, ram_write (icache always 0), data_to_ram (dcache write only, else hold previous), grant_dc.
  - Next state ISSUE; ram_en=1 from the following cycle.
  - No request: stay in IDLE.
- ISSUE:
  - ram_en=1; address, command and data registers constant.
  - On ram_rdy=1: capture ram_rdata into winner's rdata register (reads only; a write leaves dc_rdata unchanged), update last_grant, go to DONE, ram_en=0 from the next cycle.
  - req inputs are ignored in ISSUE.
- DONE (exactly 1 cycle):
  - Winner's rdy=1, ram_en=0, then go to IDLE.
  - The requester drops req on the clock edge ending DONE.
  - Minimum request-to-request spacing is therefore one IDLE cycle. This guarantees ram_en is low for ≥2 cycles between transactions.

Latency:
- req sampled at edge N; ram_en high from N+1.
- ram_rdy at edge M gives rdy high during cycle M+1.
- Minimum total latency: 3 cycles plus controller latency.

Other rules:
- ram_rdy outside ISSUE is ignored.
- A requester dropping req while ISSUE is in progress does not abort the transaction; rdy is still pulsed.

Watchdog:
- 16-bit counter clears on entry to ISSUE and increments each ISSUE cycle, saturating.
- timeout_err sets when the counter reaches TIMEOUT-1 while still in ISSUE.
- timeout_err is cleared only by rst.
- The transaction is not aborted.

Reset mid-operation:
- Returns to IDLE immediately with ram_en=0 and no rdy pulse.
- The system resets the DDR controller together with this block.

Test Plan:
- Icache read alone: ic_req, ic_addr=0x0000_0123 → ram_addr=0x0000_0120, ram_write=0, ram_en held until ram_rdy; ram_rdata=256'hA5…A5 → ic_rdy one cycle later with ic_rdata=A5…A5; dc_rdy stays 0.
- Dcache write: dc_write=1, dc_addr=0x40, dc_wdata=256'h1 → data_to_ram=1, ram_write=1; after ram_rdy: dc_rdy pulses and dc_rdata is unchanged.
- Simultaneous ic_req and dc_req after reset → dcache granted first (grant_dc=1), then icache; both rdy pulses arrive in that order with ram_en low ≥2 cycles between.
- Both requesters re-request continuously for 4 transactions → grants alternate DC, IC, DC, IC.
- TIMEOUT=8, ram_rdy withheld → timeout_err rises in the 8th ISSUE cycle and stays 1 after a later ram_rdy completes normally.
- rst asserted 2 cycles into ISSUE → next cycle ram_en=0, busy=0, no rdy pulse, timeout_err=0; a new ic_req afterwards completes normally.
